// File: rtl/act_bank.sv
// act_bank: Avalon-MM responder for one on-chip activation SRAM bank.
//
// Accepts byte-addressed 32-bit reads and writes from a dot-product
// accelerator master port. Reads return in order after LATENCY cycles
// through a valid/data shift pipeline. slave_waitrequest is raised while the
// bank clears itself after reset (one word per cycle, DEPTH cycles) and while
// MAX_PENDING reads are in flight.
//
// Parameters:
//   DEPTH       words in the bank (power of two, 16..65536)
//   LATENCY     read accept to readdatavalid, 1..4 cycles
//   MAX_PENDING in-flight read limit, 1..LATENCY
//
// Ports:
//   clk                  clock, all state on rising edge
//   rst                  asynchronous active-high reset
//   slave_waitrequest    high = request not accepted this cycle
//   slave_address        byte address; word index = [log2(DEPTH)+1:2]
//   slave_read           read request
//   slave_readdata       read return data (holds last value between returns)
//   slave_readdatavalid  one-cycle pulse per returned read
//   slave_write          write request (wins if read is also high)
//   slave_writedata      write data
//   slave_byteenable     byte-lane mask for writes
//
// Optional feature: define ACT_BANK_STALL_EN to add an LFSR that randomly
// forces waitrequest high in READY, for stressing master handshakes.
module act_bank #(
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 2,
  parameter int MAX_PENDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_PENDING + 1);

  typedef enum logic {INIT, READY} state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      clr_cnt_reg, clr_cnt_next;
  logic [CW-1:0]      pend_cnt_reg, pend_cnt_next;
  logic [LATENCY-1:0] valid_reg;
  logic [31:0]        data_reg [LATENCY];
  logic               data_seen_reg;
  logic [31:0]        mem [DEPTH];

  logic               stall;
  logic [AW-1:0]      word_idx;
  logic               rd_accept;
  logic               wr_accept;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [AW-1:0]      mem_widx;
  logic [31:0]        mem_wdata;

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{slave_address[31:AW+2], slave_address[1:0]};

  assign word_idx = slave_address[AW+1:2];

`ifdef ACT_BANK_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; runs every cycle including INIT.
  logic [15:0] lfsr_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0],
                   lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end
  assign stall = (lfsr_reg[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Next state and waitrequest. waitrequest depends only on state, pending
  // count and stall so the master can never form a combinational loop.
  always_comb begin
    state_next        = state_reg;
    clr_cnt_next      = clr_cnt_reg;
    slave_waitrequest = 1'b1;
    case (state_reg)
      INIT: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == AW'(DEPTH - 1)) begin
          state_next = READY;
        end
      end
      READY: begin
        slave_waitrequest = (pend_cnt_reg == CW'(MAX_PENDING)) || stall;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // A simultaneous read+write is served as a write only.
  assign wr_accept = slave_write & ~slave_waitrequest;
  assign rd_accept = slave_read & ~slave_write & ~slave_waitrequest;

  // Single write port shared by the post-reset clear and master writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_widx  = word_idx;
    mem_wdata = slave_writedata;
    if (state_reg == INIT) begin
      mem_we    = 1'b1;
      mem_be    = 4'hF;
      mem_widx  = clr_cnt_reg;
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
      mem_be = slave_byteenable;
    end
  end

  // Retire happens at the edge that ends the readdatavalid cycle, so a
  // full count with a retiring response still holds waitrequest for that
  // cycle.
  always_comb begin
    pend_cnt_next = pend_cnt_reg;
    if (rd_accept && !slave_readdatavalid) begin
      pend_cnt_next = pend_cnt_reg + 1'b1;
    end else if (!rd_accept && slave_readdatavalid) begin
      pend_cnt_next = pend_cnt_reg - 1'b1;
    end
  end

  // Memory array and read-data pipeline carry no reset so they map to block
  // RAM and plain registers; each data stage loads only when its input is
  // valid, so the final stage naturally holds the last returned word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if (rd_accept) begin
      data_reg[0] <= mem[word_idx];
    end
    for (int s = 1; s < LATENCY; s++) begin
      if (valid_reg[s-1]) begin
        data_reg[s] <= data_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= INIT;
      clr_cnt_reg   <= '0;
      pend_cnt_reg  <= '0;
      valid_reg     <= '0;
      data_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      pend_cnt_reg  <= pend_cnt_next;
      valid_reg     <= LATENCY'({valid_reg, rd_accept});
      data_seen_reg <= data_seen_reg | valid_reg[LATENCY-1];
    end
  end

  assign slave_readdatavalid = valid_reg[LATENCY-1];
  // The unreset data pipeline is masked to zero until the first response
  // after reset has been delivered.
  assign slave_readdata = (valid_reg[LATENCY-1] | data_seen_reg) ?
                          data_reg[LATENCY-1] : '0;

  // Simultaneous read and write is a master protocol error.
  assert property (@(posedge clk) disable iff (rst) !(slave_read && slave_write));

endmodule

// File: tb/tb_act_bank.sv
module tb_act_bank;

  localparam int DEPTH       = 16;
  localparam int LATENCY     = 2;
  localparam int MAX_PENDING = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [31:0] slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic [3:0]  slave_byteenable = '0;

  act_bank #(
    .DEPTH(DEPTH),
    .LATENCY(LATENCY),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk),
    .rst(rst),
    .slave_waitrequest(slave_waitrequest),
    .slave_address(slave_address),
    .slave_read(slave_read),
    .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid),
    .slave_write(slave_write),
    .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ready_wait_hi = 0;
  bit ready_flag = 1'b0;

  // Reference model: word array plus FIFO of expected responses.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_data_q [$];
  int          exp_cyc_q [$];
  logic [31:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int widx(logic [31:0] addr);
    return int'(addr[$clog2(DEPTH)+1:2]);
  endfunction

  // Monitor: pops the scoreboard on every returned read.
  always @(negedge clk) begin
    logic [31:0] d;
    int          c;
    if (rst) begin
      check("rdv_in_reset", {31'd0, slave_readdatavalid}, 32'd0);
      check("readdata_in_reset", slave_readdata, 32'd0);
    end else begin
      if (ready_flag && slave_waitrequest) ready_wait_hi++;
      if (slave_readdatavalid) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_rdv", 32'd1, 32'd0);
        end else begin
          d = exp_data_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("read_data", slave_readdata, d);
          check("read_latency", 32'(cyc), 32'(c));
          $display("read return data=%08h exp=%08h cycle=%0d", slave_readdata, d, cyc);
          last_data = d;
        end
      end else begin
        check("readdata_hold", slave_readdata, last_data);
      end
    end
  end

  // Issue one request and hold it until accepted (bounded).
  task automatic issue(input bit is_wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    int waited = 0;
    bit done = 1'b0;
    int pend;
    slave_address    = addr;
    slave_read       = !is_wr;
    slave_write      = is_wr;
    slave_writedata  = data;
    slave_byteenable = be;
    while (!done) begin
      @(negedge clk);
      #1;
      if (!slave_waitrequest) begin
        pend = exp_data_q.size() + int'(slave_readdatavalid);
        check("pending_limit", 32'(pend < MAX_PENDING), 32'd1);
        if (is_wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[widx(addr)][8*b +: 8] = data[8*b +: 8];
          $display("write addr=%08h data=%08h be=%h cycle=%0d", addr, data, be, cyc + 1);
        end else begin
          exp_data_q.push_back(ref_mem[widx(addr)]);
          exp_cyc_q.push_back(cyc + LATENCY);
        end
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("accept_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
    end
    slave_read  = 1'b0;
    slave_write = 1'b0;
  endtask

  // Release reset and measure how long waitrequest stays high.
  task automatic release_and_measure();
    int n = 0;
    bit low_seen = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 100 && !low_seen; i++) begin
      @(negedge clk);
      if (slave_waitrequest) n++;
      else low_seen = 1'b1;
    end
    check("init_seen_low", {31'd0, low_seen}, 32'd1);
`ifdef ACT_BANK_STALL_EN
    check("init_len_min", 32'(n >= DEPTH), 32'd1);
`else
    check("init_len", 32'(n), 32'(DEPTH));
`endif
    $display("init waitrequest cycles=%0d", n);
    ready_flag = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_flag = 1'b0;
    exp_data_q.delete();
    exp_cyc_q.delete();
    last_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    @(negedge clk);
    check("rst_waitrequest", {31'd0, slave_waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    release_and_measure();

    // Freshly cleared word
    issue(1'b0, 32'h0000_003C, '0, 4'h0);

    // Byte-lane merge
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    issue(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101);
    issue(1'b0, 32'h0000_0010, '0, 4'h0);

    // Back-to-back reads of 1..5
    for (int i = 0; i < 5; i++) issue(1'b1, 32'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 5; i++) issue(1'b0, 32'(i * 4), '0, 4'h0);

    // Alias wrap
    issue(1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF);
    issue(1'b0, 32'h0000_0000, '0, 4'h0);

    // Reset with a read still in flight
    issue(1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hF);
    issue(1'b0, 32'h0000_0008, '0, 4'h0);
    issue(1'b0, 32'h0000_000C, '0, 4'h0);
    do_reset();
    release_and_measure();
    issue(1'b0, 32'h0000_0008, '0, 4'h0);
    issue(1'b0, 32'h0000_0010, '0, 4'h0);

    // Randomized traffic with aliased and misaligned addresses
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1)
        issue(1'b1, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      else
        issue(1'b0, $urandom(), '0, 4'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // Drain
    for (int i = 0; i < 50 && exp_data_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(exp_data_q.size()), 32'd0);
    check("ready_waitrequest_seen", 32'(ready_wait_hi > 0), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
